alu_arbiter: RTL and testbench

Shares one instance of the 32-bit `ALU` between two independent requesters, such as an instruction sequencer and a test/debug port.
- Arbitrates between the requesters round-robin and latches the winner's operands and opsel.
- Runs the ALU for one cycle and registers the result and flags.
- Returns a tagged response over a valid/ready handshake with backpressure.
- Rejects opsel codes outside the ALU's defined range 0–8 without disturbing the datapath.

---
 rtl/alu_pkg.sv | 15 +
 rtl/ALU.sv | 48 ++++
 rtl/alu_arbiter.sv | 91 +++++++++
 tb/tb_alu_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opsel codes, arbiter FSM encoding and requester id width
package alu_pkg;
  localparam int OP_MAX = 8;
  localparam int ID_W = 1;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/ALU.sv
// ALU: combinational WIDTH-bit ALU (add/sub/and/or/xor/sll/srl/sra/slt) with equal, carry (no-borrow on sub) and signed overflow flags
module ALU
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPSEL_W = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OPSEL_W-1:0] opsel,
  output logic [WIDTH-1:0]   result,
  output logic               equal,
  output logic               carry,
  output logic               overflow
);
  localparam int SH_W = $clog2(WIDTH);
  logic [WIDTH:0] sum, diff;
  logic [SH_W-1:0] sh;
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign sh = b[SH_W-1:0];
  assign equal = a == b;
  always_comb begin
    result = '0;
    carry = 1'b0;
    overflow = 1'b0;
    case (opsel)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry = !diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLL: result = a << sh;
      OP_SRL: result = a >> sh;
      OP_SRA: result = $signed(a) >>> sh;
      OP_SLT: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with registered, tagged valid/ready response
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPSEL_W = 4,
  parameter int OP_MAX = alu_pkg::OP_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [OPSEL_W-1:0] req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [OPSEL_W-1:0] req1_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_equal,
  output logic               rsp_carry,
  output logic               rsp_overflow,
  output logic               rsp_illegal
);
  import alu_pkg::*;
  localparam logic [OPSEL_W-1:0] OP_LIM = OP_MAX[OPSEL_W-1:0];
  state_t state, nxt;
  logic [ID_W-1:0] last_id, cur_id;
  logic [WIDTH-1:0] a_r, b_r, alu_res;
  logic [OPSEL_W-1:0] op_r;
  logic alu_eq, alu_c, alu_v, g1, accept, illegal;
  // requester 1 wins when alone, or when both ask and 0 was served last
  assign g1 = req1_valid && (!req0_valid || last_id == 1'b0);
  assign accept = req0_ready || req1_ready;
  assign illegal = op_r > OP_LIM;
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (accept ? EXEC : IDLE) :
          state == EXEC ? RESP :
          (state == RESP && !rsp_ready) ? RESP : IDLE;
  // readies are masked during reset so nothing is accepted only to be discarded
  always_comb begin
    req0_ready = state == IDLE && !reset && req0_valid && !g1;
    req1_ready = state == IDLE && !reset && g1;
    rsp_valid = state == RESP;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
      op_r <= '0;
      cur_id <= '0;
      last_id <= '1;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_equal <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      if (accept) begin
        a_r <= req1_ready ? req1_a : req0_a;
        b_r <= req1_ready ? req1_b : req0_b;
        op_r <= req1_ready ? req1_op : req0_op;
        cur_id <= req1_ready;
        last_id <= req1_ready;
      end
      if (state == EXEC) begin
        rsp_result <= illegal ? '0 : alu_res;
        rsp_equal <= !illegal && alu_eq;
        rsp_carry <= !illegal && alu_c;
        rsp_overflow <= !illegal && alu_v;
        rsp_illegal <= illegal;
        rsp_id <= cur_id;
      end
    end
  end
  ALU #(.WIDTH(WIDTH), .OPSEL_W(OPSEL_W)) u_alu (
    .a(a_r),
    .b(b_r),
    .opsel(op_r),
    .result(alu_res),
    .equal(alu_eq),
    .carry(alu_c),
    .overflow(alu_v)
  );
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench against a behavioural arbiter/ALU model
module tb_alu_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
  logic req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0, rsp_result;
  logic [3:0] req0_op = '0, req1_op = '0;
  logic rsp_equal, rsp_carry, rsp_overflow, rsp_illegal;
  int n_cmp = 0, n_err = 0;
  bit last_id = 1'b1;
  typedef struct {
    logic [31:0] res;
    logic eq, c, v, ill;
  } rsp_t;
  always #5 clk = ~clk;
  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_equal(rsp_equal), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    rsp_t r;
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.res = '0;
    r.eq = 1'b0;
    r.c = 1'b0;
    r.v = 1'b0;
    r.ill = op > 4'd8;
    if (r.ill) return r;
    r.eq = a == b;
    case (op)
      4'd0: begin
        r.res = a + b;
        r.c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
        t = sa + sb;
        r.v = t > 64'sd2147483647 || t < -64'sd2147483648;
      end
      4'd1: begin
        r.res = a - b;
        r.c = a >= b;
        t = sa - sb;
        r.v = t > 64'sd2147483647 || t < -64'sd2147483648;
      end
      4'd2: r.res = a & b;
      4'd3: r.res = a | b;
      4'd4: r.res = a ^ b;
      4'd5: r.res = a << (b % 32);
      4'd6: r.res = a >> (b % 32);
      4'd7: r.res = $signed(a) >>> (b % 32);
      default: r.res = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    return r;
  endfunction
  // starts right after a negedge with the arbiter idle, ends at a negedge idle again
  task automatic do_op(input bit v0, input bit v1,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] o0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] o1,
                       input int bp);
    bit g;
    rsp_t e;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    rsp_ready = bp == 0;
    g = (v0 && v1) ? !last_id : v1;
    #1;
    chk("req0_ready", req0_ready, !g);
    chk("req1_ready", req1_ready, g);
    last_id = g;
    e = g ? model(a1, b1, o1) : model(a0, b0, o0);
    @(posedge clk); #1;
    if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
    @(negedge clk);
    chk("exec_no_valid", {rsp_valid, req0_ready, req1_ready}, 3'b000);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_id", rsp_id, g);
    chk("rsp_result", rsp_result, e.res);
    chk("rsp_flags{ill,eq,c,v}", {rsp_illegal, rsp_equal, rsp_carry, rsp_overflow}, {e.ill, e.eq, e.c, e.v});
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_illegal, rsp_equal, rsp_carry, rsp_overflow, rsp_result, req0_ready, req1_ready},
          {1'b1, g, e.ill, e.eq, e.c, e.v, e.res, 2'b00});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("retired", rsp_valid, 1'b0);
  endtask
  initial begin
    int v;
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp", {rsp_valid, rsp_id, rsp_illegal, rsp_equal, rsp_carry, rsp_overflow, rsp_result}, '0);
    chk("reset_ready", {req0_ready, req1_ready}, 2'b00);
    reset = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    do_op(1, 0, 32'd1, 32'd1, 4'd0, 32'd0, 32'd0, 4'd0, 0);
    for (int i = 0; i < 6; i++)
      do_op(1, 1, 32'd5, 32'd3, 4'(i % 9), 32'd7, 32'd7, 4'((i + 3) % 9), 0);
    do_op(1, 1, $urandom, $urandom, 4'd0, $urandom, $urandom, 4'd1, 10);
    do_op(0, 1, 32'd0, 32'd0, 4'd0, 32'd1, 32'd1, 4'd9, 0);
    do_op(0, 1, 32'd0, 32'd0, 4'd0, 32'd1, 32'd1, 4'd15, 0);
    do_op(1, 0, 32'd9, 32'd4, 4'd1, 32'd0, 32'd0, 4'd0, 0);
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_op = 4'd0;
    #1;
    chk("rst_test_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_test_valid", rsp_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_id = 1'b1;
    chk("rst_discard", {rsp_valid, rsp_result}, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 1'b0);
    end
    do_op(1, 1, 32'd2, 32'd2, 4'd0, 32'd4, 32'd4, 4'd0, 0);
    for (int op = 0; op <= 8; op++)
      do_op(op % 2 == 0, op % 2 == 1, $urandom, $urandom, 4'(op), $urandom, $urandom, 4'(op), 0);
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(1, 3);
      do_op(v[0], v[1], $urandom, $urandom, 4'($urandom_range(0, 15)),
            $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
